// File: rtl/ibex_fetch_aligner.sv
// Fetch-word buffer and aligner: splits 32-bit fetch words into 16/32-bit instructions, including straddling ones.
// Latency: a pushed word can produce an instruction one cycle later; there is no input-to-output bypass.
// Backpressure: in_ready_o depends only on FIFO occupancy; out_ready_i stalls the output with stable data.
// Optional stall counter output is enabled by defining IBEX_ALIGNER_STALL_CNT_EN.
module ibex_fetch_aligner #(
    parameter int unsigned DEPTH     = 3,
    parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic [31:0] clear_addr_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_rdata_i,
    input  logic        in_err_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_instr_o,
    output logic [31:0] out_addr_o,
    output logic        out_err_o,
    output logic        out_err_plus2_o
`ifdef IBEX_ALIGNER_STALL_CNT_EN
    ,
    output logic [31:0] stall_cnt_o
`endif
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [31:0]   mem_rdata [DEPTH];
    logic          mem_err   [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] nx_ptr;
    logic [CW-1:0] count;
    logic          offset;
    logic [31:0]   pc;

    logic [31:0] head_rdata;
    logic        head_err;
    logic [15:0] next_lo;
    logic        next_err;
    logic [15:0] half;
    logic        is_comp;
    logic        straddle;
    logic        have_next;
    logic        push;
    logic        fire;
    logic        pop;
    logic        adv_pop;
    logic        offset_nxt;
    logic [31:0] pc_step;
    logic        unused_addr_bit0;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign unused_addr_bit0 = clear_addr_i[0];

    assign nx_ptr     = ptr_inc(rd_ptr);
    assign head_rdata = mem_rdata[rd_ptr];
    assign head_err   = mem_err[rd_ptr];
    assign next_lo    = mem_rdata[nx_ptr][15:0];
    assign next_err   = mem_err[nx_ptr];
    assign have_next  = (count >= CW'(2));

    assign half     = offset ? head_rdata[31:16] : head_rdata[15:0];
    assign is_comp  = (half[1:0] != 2'b11);
    assign straddle = offset && !is_comp;

    assign in_ready_o  = (count < CW'(DEPTH));
    assign out_valid_o = (count >= CW'(1)) && (!straddle || head_err || have_next);
    assign out_addr_o  = pc;

    // Second-word error only counts once that word is actually buffered.
    assign out_err_o       = head_err || (straddle && have_next && next_err);
    assign out_err_plus2_o = straddle && have_next && !head_err && next_err;

    // An erroring head ignores the next word so the output stays stable under later pushes.
    always_comb begin
        out_instr_o = 32'h0;
        if (!offset) begin
            out_instr_o = is_comp ? {16'h0, head_rdata[15:0]} : head_rdata;
        end else if (is_comp) begin
            out_instr_o = {16'h0, head_rdata[31:16]};
        end else begin
            out_instr_o = {(head_err ? 16'h0 : next_lo), head_rdata[31:16]};
        end
    end

    assign push = in_valid_i && in_ready_o && !clear_i;
    assign fire = out_valid_o && out_ready_i && !clear_i;

    always_comb begin
        adv_pop    = 1'b1;
        offset_nxt = 1'b0;
        pc_step    = 32'd4;
        if (out_err_o) begin
            adv_pop    = 1'b1;
            offset_nxt = 1'b0;
        end else if (!offset && is_comp) begin
            adv_pop    = 1'b0;
            offset_nxt = 1'b1;
            pc_step    = 32'd2;
        end else if (!offset) begin
            offset_nxt = 1'b0;
        end else if (is_comp) begin
            offset_nxt = 1'b0;
            pc_step    = 32'd2;
        end else begin
            offset_nxt = 1'b1;
        end
    end

    assign pop = fire && adv_pop;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            offset <= 1'b0;
            pc     <= BOOT_ADDR;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_rdata[i] <= 32'h0;
                mem_err[i]   <= 1'b0;
            end
        end else if (clear_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            offset <= clear_addr_i[1];
            pc     <= {clear_addr_i[31:1], 1'b0};
        end else begin
            if (push) begin
                mem_rdata[wr_ptr] <= in_rdata_i;
                mem_err[wr_ptr]   <= in_err_i;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= nx_ptr;
            end
            count <= count + CW'(push) - CW'(pop);
            if (fire) begin
                offset <= offset_nxt;
                pc     <= pc + pc_step;
            end
        end
    end

`ifdef IBEX_ALIGNER_STALL_CNT_EN
    logic stall_cond;

    // Waiting on the upper half of a straddling instruction; survives clear_i.
    assign stall_cond = straddle && !head_err && (count == CW'(1));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_o <= 32'h0;
        end else if (stall_cond && (stall_cnt_o != 32'hFFFF_FFFF)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_ibex_fetch_aligner.sv
// Directed self-checking bench for ibex_fetch_aligner (default build, DEPTH=3).
module tb_ibex_fetch_aligner;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        clear_i;
    logic [31:0] clear_addr_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic [31:0] in_rdata_i;
    logic        in_err_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_instr_o;
    logic [31:0] out_addr_o;
    logic        out_err_o;
    logic        out_err_plus2_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk_i = ~clk_i;

    ibex_fetch_aligner #(
        .DEPTH     (3),
        .BOOT_ADDR (32'h0000_0080)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .clear_addr_i    (clear_addr_i),
        .in_valid_i      (in_valid_i),
        .in_ready_o      (in_ready_o),
        .in_rdata_i      (in_rdata_i),
        .in_err_i        (in_err_i),
        .out_valid_o     (out_valid_o),
        .out_ready_i     (out_ready_i),
        .out_instr_o     (out_instr_o),
        .out_addr_o      (out_addr_o),
        .out_err_o       (out_err_o),
        .out_err_plus2_o (out_err_plus2_o)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_word(input logic [31:0] data, input logic err);
        in_valid_i = 1'b1;
        in_rdata_i = data;
        in_err_i   = err;
        tick();
        in_valid_i = 1'b0;
        in_err_i   = 1'b0;
    endtask

    task automatic consume();
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
    endtask

    task automatic do_clear(input logic [31:0] addr);
        clear_i      = 1'b1;
        clear_addr_i = addr;
        tick();
        clear_i = 1'b0;
    endtask

    logic [31:0] bp_words [3];

    initial begin
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        clear_addr_i = 32'h0;
        in_valid_i   = 1'b0;
        in_rdata_i   = 32'h0;
        in_err_i     = 1'b0;
        out_ready_i  = 1'b0;
        tick();
        tick();
        rst_i = 1'b0;

        check("rst_valid", 32'(out_valid_o), 32'd0);
        check("rst_ready", 32'(in_ready_o), 32'd1);
        check("rst_instr", out_instr_o, 32'h0);
        check("rst_addr", out_addr_o, 32'h0000_0080);
        check("rst_err", 32'(out_err_o), 32'd0);
        check("rst_plus2", 32'(out_err_plus2_o), 32'd0);

        // Two compressed halves from one word.
        push_word(32'h0001_4501, 1'b0);
        check("c0_valid", 32'(out_valid_o), 32'd1);
        check("c0_instr", out_instr_o, 32'h0000_4501);
        check("c0_addr", out_addr_o, 32'h0000_0080);
        consume();
        check("c1_valid", 32'(out_valid_o), 32'd1);
        check("c1_instr", out_instr_o, 32'h0000_0001);
        check("c1_addr", out_addr_o, 32'h0000_0082);
        consume();
        check("c_drained", 32'(out_valid_o), 32'd0);
        check("c_pc", out_addr_o, 32'h0000_0084);

        // Clear to an odd halfword; upper half 0x0513 is a 32-bit opcode.
        do_clear(32'h0000_0102);
        check("clr_valid", 32'(out_valid_o), 32'd0);
        check("clr_addr", out_addr_o, 32'h0000_0102);
        push_word(32'h0513_4501, 1'b0);
        check("u0_wait", 32'(out_valid_o), 32'd0);
        push_word(32'h1234_0000, 1'b0);
        check("u0_valid", 32'(out_valid_o), 32'd1);
        check("u0_instr", out_instr_o, 32'h0000_0513);
        check("u0_addr", out_addr_o, 32'h0000_0102);
        consume();
        check("u1_instr", out_instr_o, 32'h0000_1234);
        check("u1_addr", out_addr_o, 32'h0000_0106);
        consume();
        check("u1_drained", 32'(out_valid_o), 32'd0);

        // Straddle waits for the second word.
        do_clear(32'h0000_0202);
        push_word(32'h0093_0001, 1'b0);
        check("s_wait", 32'(out_valid_o), 32'd0);
        push_word(32'hABCD_0010, 1'b0);
        check("s_valid", 32'(out_valid_o), 32'd1);
        check("s_instr", out_instr_o, 32'h0010_0093);
        check("s_addr", out_addr_o, 32'h0000_0202);
        check("s_err", 32'(out_err_o), 32'd0);
        consume();
        check("s_next_instr", out_instr_o, 32'h0000_ABCD);
        check("s_next_addr", out_addr_o, 32'h0000_0206);
        consume();
        check("s_drained", 32'(out_valid_o), 32'd0);

        // Error only on the upper-half word.
        do_clear(32'h0000_0302);
        push_word(32'h0093_1111, 1'b0);
        push_word(32'h5555_6666, 1'b1);
        check("e2_valid", 32'(out_valid_o), 32'd1);
        check("e2_err", 32'(out_err_o), 32'd1);
        check("e2_plus2", 32'(out_err_plus2_o), 32'd1);
        check("e2_addr", out_addr_o, 32'h0000_0302);
        check("e2_instr", out_instr_o, 32'h6666_0093);
        consume();
        check("e1_valid", 32'(out_valid_o), 32'd1);
        check("e1_err", 32'(out_err_o), 32'd1);
        check("e1_plus2", 32'(out_err_plus2_o), 32'd0);
        check("e1_addr", out_addr_o, 32'h0000_0306);

        // Backpressure: fill, stall 5 cycles with an extra word offered, then drain.
        do_clear(32'h0000_0400);
        bp_words[0] = 32'h1111_1113;
        bp_words[1] = 32'h2222_2223;
        bp_words[2] = 32'h3333_3333;
        in_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_rdata_i = bp_words[i];
            tick();
        end
        in_rdata_i = 32'h4444_4443;
        for (int i = 0; i < 5; i++) begin
            check("bp_ready", 32'(in_ready_o), 32'd0);
            check("bp_instr", out_instr_o, 32'h1111_1113);
            check("bp_addr", out_addr_o, 32'h0000_0400);
            tick();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("dr_valid", 32'(out_valid_o), 32'd1);
            check("dr_instr", out_instr_o, bp_words[i]);
            check("dr_addr", out_addr_o, 32'h0000_0400 + 32'(4 * i));
            tick();
        end
        out_ready_i = 1'b0;
        check("dr_empty", 32'(out_valid_o), 32'd0);
        check("dr_ready", 32'(in_ready_o), 32'd1);

        // Clear concurrent with push and pop.
        do_clear(32'h0000_0500);
        push_word(32'h0000_0001, 1'b0);
        check("cc_pre_valid", 32'(out_valid_o), 32'd1);
        clear_i      = 1'b1;
        clear_addr_i = 32'h0000_0602;
        in_valid_i   = 1'b1;
        in_rdata_i   = 32'h7777_7777;
        out_ready_i  = 1'b1;
        check("cc_ready_during", 32'(in_ready_o), 32'd1);
        tick();
        clear_i     = 1'b0;
        in_valid_i  = 1'b0;
        out_ready_i = 1'b0;
        check("cc_valid", 32'(out_valid_o), 32'd0);
        check("cc_addr", out_addr_o, 32'h0000_0602);
        check("cc_ready", 32'(in_ready_o), 32'd1);
        tick();
        check("cc_still_empty", 32'(out_valid_o), 32'd0);
        push_word(32'h1235_8888, 1'b0);
        check("cc_new_instr", out_instr_o, 32'h0000_1235);
        check("cc_new_addr", out_addr_o, 32'h0000_0602);

        // Mid-operation reset.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("mrst_valid", 32'(out_valid_o), 32'd0);
        check("mrst_addr", out_addr_o, 32'h0000_0080);
        check("mrst_instr", out_instr_o, 32'h0);
        check("mrst_ready", 32'(in_ready_o), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
